// File: rtl/ripple_capture_pkg.sv
// Shared types, default widths and the wrap test used by the ripple counter capture block.
package ripple_capture_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } cap_state_t;

  localparam int CNT_W_DEF    = 4;
  localparam int EXT_W_DEF    = 12;
  localparam int STABLE_N_DEF = 2;

  // A forward-only counter whose new low value is below the old one has rolled over.
  function automatic logic wrapped(input logic [31:0] new_low, input logic [31:0] old_low);
    return new_low < old_low;
  endfunction

endpackage

// File: rtl/ripple_count_capture_if.sv
// Bus between the ripple counter capture block and its user; snap signals exist only
// when RIPPLE_CAPTURE_SNAPSHOT_EN is defined.
interface ripple_count_capture_if
  import ripple_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int EXT_W = EXT_W_DEF
);

  logic [CNT_W-1:0] q_in;
  logic             clr;
  logic [EXT_W-1:0] cmp_val;
  logic [EXT_W-1:0] count;
  logic             count_vld;
  logic             match;
  logic             wrap;
  logic             ovf;

`ifdef RIPPLE_CAPTURE_SNAPSHOT_EN
  logic             snap;
  logic [EXT_W-1:0] snap_count;

  modport master (
    output q_in, clr, cmp_val, snap,
    input  count, count_vld, match, wrap, ovf, snap_count
  );

  modport slave (
    input  q_in, clr, cmp_val, snap,
    output count, count_vld, match, wrap, ovf, snap_count
  );
`else
  modport master (
    output q_in, clr, cmp_val,
    input  count, count_vld, match, wrap, ovf
  );

  modport slave (
    input  q_in, clr, cmp_val,
    output count, count_vld, match, wrap, ovf
  );
`endif

endinterface

// File: rtl/ripple_sync_filter.sv
// Two-flop synchroniser plus stability filter for a glitchy asynchronous ripple count.
// Accept fires STABLE_N+1 edges after q_in settles; no backpressure, runs every cycle.
module ripple_sync_filter
  import ripple_capture_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STABLE_N = STABLE_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] q_in,
  output logic             accept,
  output logic [CNT_W-1:0] acc_val
);

  localparam int STAB_W = $clog2(STABLE_N) + 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N - 1);

  logic [CNT_W-1:0]  s1;
  logic [CNT_W-1:0]  s2;
  logic [CNT_W-1:0]  s2_d;
  logic [CNT_W-1:0]  acc;
  logic [STAB_W-1:0] stab;
  logic [STAB_W-1:0] run;
  logic              stab_ok;

  // run = consecutive equal samples including this cycle, saturating at STABLE_N-1
  always_comb begin
    run = '0;
    if (s2 == s2_d) begin
      run = (stab == STAB_MAX) ? STAB_MAX : stab + 1'b1;
    end
  end

  generate
    if (STABLE_N == 1) begin : g_no_filter
      assign stab_ok = 1'b1;
    end else begin : g_filter
      assign stab_ok = (run == STAB_MAX);
    end
  endgenerate

  assign accept  = stab_ok && (s2 != acc);
  assign acc_val = s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      s2_d <= '0;
      stab <= '0;
      acc  <= '0;
    end else begin
      s1   <= q_in;
      s2   <= s1;
      s2_d <= s2;
      stab <= run;
      if (accept) begin
        acc <= s2;
      end
    end
  end

endmodule

// File: rtl/ripple_count_capture.sv
// Extends a filtered ripple count into EXT_W bits with vld/match/wrap pulses and sticky ovf.
// Count updates STABLE_N+2 edges after q_in settles; no backpressure, strobes are 1-cycle.
// Optional snapshot register under RIPPLE_CAPTURE_SNAPSHOT_EN.
module ripple_count_capture
  import ripple_capture_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EXT_W    = EXT_W_DEF,
  parameter int STABLE_N = STABLE_N_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  ripple_count_capture_if.slave  bus
);

  localparam int UP_W = EXT_W - CNT_W;

  logic             accept;
  logic [CNT_W-1:0] acc_val;

  cap_state_t       state, state_n;
  logic [UP_W-1:0]  upper, upper_n;
  logic [CNT_W-1:0] low, low_n;
  logic             vld_q, vld_n;
  logic             wrap_q, wrap_n;
  logic             match_q, match_n;
  logic             ovf_q, ovf_n;

  ripple_sync_filter #(
    .CNT_W    (CNT_W),
    .STABLE_N (STABLE_N)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .q_in    (bus.q_in),
    .accept  (accept),
    .acc_val (acc_val)
  );

  always_comb begin
    state_n = state;
    upper_n = upper;
    low_n   = low;
    vld_n   = 1'b0;
    wrap_n  = 1'b0;
    ovf_n   = ovf_q;
    if (bus.clr) begin
      // an accept landing in the clear cycle is dropped; the next one re-baselines
      upper_n = '0;
      ovf_n   = 1'b0;
      state_n = INIT;
    end else if (accept) begin
      vld_n = 1'b1;
      low_n = acc_val;
      if (state == INIT) begin
        upper_n = '0;
        state_n = TRACK;
      end else if (wrapped(32'(acc_val), 32'(low))) begin
        wrap_n  = 1'b1;
        upper_n = upper + 1'b1;
        if (&upper) begin
          ovf_n = 1'b1;
        end
      end
    end
    match_n = vld_n && ({upper_n, low_n} == bus.cmp_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      upper   <= '0;
      low     <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      upper   <= upper_n;
      low     <= low_n;
      vld_q   <= vld_n;
      wrap_q  <= wrap_n;
      match_q <= match_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.count     = {upper, low};
  assign bus.count_vld = vld_q;
  assign bus.wrap      = wrap_q;
  assign bus.match     = match_q;
  assign bus.ovf       = ovf_q;

`ifdef RIPPLE_CAPTURE_SNAPSHOT_EN
  logic [EXT_W-1:0] snap_q;

  // samples the registered count, so a coincident update yields the pre-update value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else if (bus.snap) begin
      snap_q <= {upper, low};
    end
  end

  assign bus.snap_count = snap_q;
`endif

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench: two DUTs (EXT_W 12 and 6) share stimulus; a model pushes expected updates.
module tb_ripple_count_capture;
  import ripple_capture_pkg::*;

  localparam int LAT = STABLE_N_DEF + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  q_drv;
  logic        clr_drv;
  logic [11:0] cmp_drv;

  ripple_count_capture_if #(.CNT_W(4), .EXT_W(12)) bus12 ();
  ripple_count_capture_if #(.CNT_W(4), .EXT_W(6))  bus6 ();

  assign bus12.q_in    = q_drv;
  assign bus12.clr     = clr_drv;
  assign bus12.cmp_val = cmp_drv;
  assign bus6.q_in     = q_drv;
  assign bus6.clr      = clr_drv;
  assign bus6.cmp_val  = cmp_drv[5:0];

`ifdef RIPPLE_CAPTURE_SNAPSHOT_EN
  logic snap_drv;
  assign bus12.snap = snap_drv;
  assign bus6.snap  = snap_drv;
`endif

  ripple_count_capture #(.CNT_W(4), .EXT_W(12), .STABLE_N(STABLE_N_DEF)) u_dut12 (
    .clk (clk), .rst (rst), .bus (bus12)
  );
  ripple_count_capture #(.CNT_W(4), .EXT_W(6), .STABLE_N(STABLE_N_DEF)) u_dut6 (
    .clk (clk), .rst (rst), .bus (bus6)
  );

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] cnt;
    logic        wrp;
    logic        mat;
    logic        ovf;
    int unsigned at;
  } exp_t;

  exp_t q12[$];
  exp_t q6[$];
  exp_t m12, m6, r12, r6;

  logic [3:0] macc, mlow;
  logic       minit;
  logic [7:0] mup;
  logic       movf12, movf6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    macc = 4'h0; mlow = 4'h0; minit = 1'b1; mup = 8'h00; movf12 = 1'b0; movf6 = 1'b0;
  endtask

  task automatic model_clr();
    minit = 1'b1; mup = 8'h00; movf12 = 1'b0; movf6 = 1'b0;
  endtask

  // Called on the negedge where q_in takes value v; pushes the update the DUTs owe us.
  task automatic model_accept(input logic [3:0] v);
    logic w;
    w = 1'b0;
    if (v != macc) begin
      macc = v;
      if (minit) begin
        minit = 1'b0;
        mup   = 8'h00;
      end else if (v < mlow) begin
        w = 1'b1;
        if (mup == 8'hFF) movf12 = 1'b1;
        if (mup[1:0] == 2'b11) movf6 = 1'b1;
        mup = mup + 8'd1;
      end
      mlow   = v;
      m12.cnt = {mup, v};
      m12.wrp = w;
      m12.mat = ({mup, v} == cmp_drv);
      m12.ovf = movf12;
      m12.at  = edge_cnt + LAT;
      m6.cnt  = {6'b0, mup[1:0], v};
      m6.wrp  = w;
      m6.mat  = ({mup[1:0], v} == cmp_drv[5:0]);
      m6.ovf  = movf6;
      m6.at   = edge_cnt + LAT;
      q12.push_back(m12);
      q6.push_back(m6);
    end
  endtask

  task automatic step(input logic [3:0] v, input int hold);
    @(negedge clk);
    q_drv = v;
    model_accept(v);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_drv = 1'b1;
    model_clr();
    @(negedge clk);
    clr_drv = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_12"}, 32'({bus12.count, bus12.count_vld, bus12.match, bus12.wrap, bus12.ovf}), 32'd0);
    chk({tag, "_6"},  32'({bus6.count, bus6.count_vld, bus6.match, bus6.wrap, bus6.ovf}), 32'd0);
  endtask

  // Scoreboard: every update pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus12.count_vld) begin
      chk("vld12_queued", 32'(q12.size() != 0), 32'd1);
      if (q12.size() != 0) begin
        r12 = q12.pop_front();
        chk("count12", 32'(bus12.count), 32'(r12.cnt));
        chk("wrap12",  32'(bus12.wrap),  32'(r12.wrp));
        chk("match12", 32'(bus12.match), 32'(r12.mat));
        chk("ovf12",   32'(bus12.ovf),   32'(r12.ovf));
        chk("lat12",   edge_cnt,         r12.at);
      end
    end else begin
      chk("idle12", 32'({bus12.match, bus12.wrap}), 32'd0);
    end
    if (bus6.count_vld) begin
      chk("vld6_queued", 32'(q6.size() != 0), 32'd1);
      if (q6.size() != 0) begin
        r6 = q6.pop_front();
        chk("count6", 32'(bus6.count), 32'(r6.cnt));
        chk("wrap6",  32'(bus6.wrap),  32'(r6.wrp));
        chk("match6", 32'(bus6.match), 32'(r6.mat));
        chk("ovf6",   32'(bus6.ovf),   32'(r6.ovf));
        chk("lat6",   edge_cnt,        r6.at);
      end
    end else begin
      chk("idle6", 32'({bus6.match, bus6.wrap}), 32'd0);
    end
  end

  logic [3:0] v;

  initial begin
    rst = 1'b1; q_drv = 4'hA; clr_drv = 1'b0; cmp_drv = 12'hFFF;
`ifdef RIPPLE_CAPTURE_SNAPSHOT_EN
    snap_drv = 1'b0;
`endif
    model_reset();

    // reset with a live input, then release and baseline
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    model_accept(4'hA);
    repeat (8) @(negedge clk);
    chk("t1_count12", 32'(bus12.count), 32'h00A);

`ifdef RIPPLE_CAPTURE_SNAPSHOT_EN
    snap_drv = 1'b1;
    @(negedge clk);
    snap_drv = 1'b0;
    chk("snap12", 32'(bus12.snap_count), 32'h00A);
`endif

    // clear, then sweep 0..15
    pulse_clr();
    for (int i = 0; i < 16; i++) step(4'(i), 8);
    chk("t2_count12", 32'(bus12.count), 32'd15);

    // two wraps
    step(4'h0, 8);
    for (int i = 1; i < 16; i++) step(4'(i), 8);
    step(4'h0, 8);
    chk("t3_count12", 32'(bus12.count), 32'd32);

    // one-cycle glitch must be filtered out
    step(4'h7, 8);
    @(negedge clk);
    q_drv = 4'hF;
    @(negedge clk);
    q_drv = 4'h7;
    repeat (7) @(negedge clk);
    step(4'h8, 8);
    chk("t4_count12", 32'(bus12.count), 32'd40);

    // compare match at 20, then cmp changes alone
    pulse_clr();
    step(4'h0, 8);
    cmp_drv = 12'd20;
    for (int i = 1; i < 16; i++) step(4'(i), 8);
    step(4'h0, 8);
    for (int i = 1; i < 10; i++) step(4'(i), 8);
    chk("t5_count12", 32'(bus12.count), 32'd25);
    repeat (6) @(negedge clk);
    cmp_drv = 12'd25;
    repeat (6) @(negedge clk);

    // run to 37 then pulse reset
    for (int i = 10; i < 16; i++) step(4'(i), 8);
    step(4'h0, 8);
    for (int i = 1; i < 6; i++) step(4'(i), 8);
    chk("t7_count12", 32'(bus12.count), 32'd37);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_accept(q_drv);
    repeat (8) @(negedge clk);
    chk("t7_recover12", 32'(bus12.count), 32'd5);

    // overflow the 6-bit instance in strides of 5
    v = 4'h5;
    for (int i = 0; i < 14; i++) begin
      v = v + 4'd5;
      step(v, 8);
    end
    chk("t6_count12", 32'(bus12.count), 32'd75);
    chk("t6_count6", 32'(bus6.count), 32'd11);
    repeat (10) @(negedge clk);
    chk("t6_ovf6_sticky", 32'(bus6.ovf), 32'd1);
    chk("t6_ovf12", 32'(bus12.ovf), 32'd0);
    pulse_clr();
    chk("t6_ovf6_clr", 32'(bus6.ovf), 32'd0);
    step(4'h3, 8);
    chk("t6_rebase6", 32'(bus6.count), 32'd3);

    chk("q12_drained", 32'(q12.size()), 32'd0);
    chk("q6_drained", 32'(q6.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
